string_index_unit: RTL

- Parametrised successor of the single-index register of the register bank.
- Holds a source index (SI), a destination index (DI) and a repeat counter (CX shadow).
- Steps SI and DI by byte or word according to a direction flag, under manual or repeated (REP) string operations.
- Sits in the register bank next to the general registers; handshakes one element at a time with the memory-access unit.

---
 rtl/string_index_unit_pkg.sv | 16 +
 rtl/string_index_unit_index.sv | 32 +++
 rtl/string_index_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/string_index_unit_pkg.sv
// Shared constants for the string index unit: FSM states, index selects, step sizes.
package string_index_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic IDX_SI = 1'b0;
  localparam logic IDX_DI = 1'b1;

  localparam int unsigned STEP_BYTE = 1;
  localparam int unsigned STEP_WORD = 2;

endpackage

// File: rtl/string_index_unit_index.sv
// One string index register (SI or DI): load beats advance, advance steps by byte/word.
module index_reg
  import string_index_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  input  logic             DF,
  input  logic             WORD,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] step;

  assign step = WORD ? WIDTH'(STEP_WORD) : WIDTH'(STEP_BYTE);

  // Modulo-2^WIDTH arithmetic wraps naturally.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      Q <= '0;
    end else if (load) begin
      Q <= load_data;
    end else if (advance) begin
      Q <= DF ? (Q - step) : (Q + step);
    end
  end

endmodule

// File: rtl/string_index_unit.sv
// SI/DI/count unit with REP sequencing; one element per REQ/ACK handshake.
module string_index_unit
  import string_index_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_ENA,
  input  logic                 LD_SEL,
  input  logic [WIDTH-1:0]     D,
  input  logic                 STEP,
  input  logic                 DF,
  input  logic                 WORD,
  input  logic                 SRC_EN,
  input  logic                 DST_EN,
  input  logic                 REP_START,
  input  logic [CNT_WIDTH-1:0] CNT_IN,
  input  logic                 ACK,
  input  logic                 ABORT,
  output logic [WIDTH-1:0]     SI_Q,
  output logic [WIDTH-1:0]     DI_Q,
  output logic [CNT_WIDTH-1:0] CNT_Q,
  output logic                 REQ,
  output logic                 BUSY,
  output logic                 DONE
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ld_si, ld_di, adv;
  logic                 req_d, busy_d, done_d;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      CNT_Q   <= '0;
      REQ     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      CNT_Q   <= cnt_d;
      REQ     <= req_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_Q;
    ld_si   = 1'b0;
    ld_di   = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (LD_ENA) begin
          ld_si = (LD_SEL == IDX_SI);
          ld_di = (LD_SEL == IDX_DI);
        end else if (REP_START) begin
          cnt_d   = CNT_IN;
          state_d = (CNT_IN == '0) ? ST_DONE : ST_XFER;
        end else if (STEP) begin
          adv = 1'b1;
        end
      end
      ST_XFER: begin
        // ACK step is applied even when ABORT arrives on the same edge.
        if (ACK) begin
          adv = 1'b1;
          if (CNT_Q != '0) begin
            cnt_d = CNT_Q - CNT_WIDTH'(1);
          end
          if (CNT_Q <= CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else if (ABORT) begin
            state_d = ST_IDLE;
          end
        end else if (ABORT) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_XFER);
    busy_d = (state_d == ST_XFER);
    done_d = (state_d == ST_DONE);
  end

  index_reg #(.WIDTH(WIDTH)) u_si (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ld_si),
    .load_data (D),
    .advance   (adv & SRC_EN),
    .DF        (DF),
    .WORD      (WORD),
    .Q         (SI_Q)
  );

  index_reg #(.WIDTH(WIDTH)) u_di (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ld_di),
    .load_data (D),
    .advance   (adv & DST_EN),
    .DF        (DF),
    .WORD      (WORD),
    .Q         (DI_Q)
  );

endmodule
